// File: rtl/button_pkg.sv
// Shared types and defaults for the button press classifier.
//   state_t                 : classifier FSM states
//   DEFAULT_LONG_CYCLES     : press length for a long press (0.5 s at 100 MHz)
//   DEFAULT_GAP_CYCLES      : max release gap for a double press (250 ms at 100 MHz)
//   cnt_width()             : counter width covering both terminal counts
package button_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        LONG_HELD,
        WAIT_SECOND,
        SECOND_PRESSED
    } state_t;

    localparam int unsigned DEFAULT_LONG_CYCLES = 50_000_000;
    localparam int unsigned DEFAULT_GAP_CYCLES  = 25_000_000;

    // Width of the shared counter: $clog2 of the larger terminal length.
    function automatic int unsigned cnt_width(input int unsigned long_cycles,
                                              input int unsigned gap_cycles);
        return $clog2((long_cycles > gap_cycles) ? long_cycles : gap_cycles);
    endfunction

endpackage

// File: rtl/press_counter.sv
// Up-counter with synchronous clear/enable and a terminal-value comparator.
//   clk, rst   : clock, synchronous active-high reset
//   clear      : synchronous clear (wins over en)
//   en         : increment enable
//   term       : terminal value to compare against
//   at_term_c  : combinational flag, count == term
module press_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] term,
    output logic             at_term_c
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

    assign at_term_c = (count == term);

endmodule

// File: rtl/button_press_classifier.sv
// Classifies debounced button gestures into short, long and double presses.
//   clk, rst      : 100 MHz system clock, synchronous active-high reset
//   debounced     : clean button level, 1 = pressed
//   short_press   : one-cycle pulse, single press with no follow-up in the gap
//   long_press    : one-cycle pulse when a press reaches LONG_CYCLES
//   double_press  : one-cycle pulse on release of a second press
//   held          : level, high while the long press is still held
module button_press_classifier
    import button_pkg::*;
#(
    parameter int unsigned LONG_CYCLES = DEFAULT_LONG_CYCLES,
    parameter int unsigned GAP_CYCLES  = DEFAULT_GAP_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic debounced,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic held
);

    localparam int unsigned CNT_W = cnt_width(LONG_CYCLES, GAP_CYCLES);
    localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'(GAP_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic             short_next;
    logic             long_next;
    logic             double_next;
    logic             held_next;
    logic             cnt_clear;
    logic             cnt_en;
    logic [CNT_W-1:0] term;
    logic             at_term_c;

    press_counter #(
        .WIDTH (CNT_W)
    ) u_press_counter (
        .clk       (clk),
        .rst       (rst),
        .clear     (cnt_clear),
        .en        (cnt_en),
        .term      (term),
        .at_term_c (at_term_c)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_press <= 1'b0;
            held         <= 1'b0;
        end else begin
            state        <= state_next;
            short_press  <= short_next;
            long_press   <= long_next;
            double_press <= double_next;
            held         <= held_next;
        end
    end

    // Next-state and next-output logic. A level change on debounced is
    // checked before the terminal count, so release/press wins a tie.
    always_comb begin
        state_next  = state;
        short_next  = 1'b0;
        long_next   = 1'b0;
        double_next = 1'b0;
        cnt_en      = 1'b0;
        term        = LONG_TERM;

        case (state)
            IDLE: begin
                if (debounced) begin
                    state_next = PRESSED;
                end
            end
            PRESSED: begin
                cnt_en = 1'b1;
                if (!debounced) begin
                    state_next = WAIT_SECOND;
                end else if (at_term_c) begin
                    state_next = LONG_HELD;
                    long_next  = 1'b1;
                end
            end
            LONG_HELD: begin
                if (!debounced) begin
                    state_next = IDLE;
                end
            end
            WAIT_SECOND: begin
                cnt_en = 1'b1;
                term   = GAP_TERM;
                if (debounced) begin
                    state_next = SECOND_PRESSED;
                end else if (at_term_c) begin
                    state_next = IDLE;
                    short_next = 1'b1;
                end
            end
            SECOND_PRESSED: begin
                if (!debounced) begin
                    state_next  = IDLE;
                    double_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Counter restarts from 0 on every state change.
        cnt_clear = (state_next != state);
        held_next = (state_next == LONG_HELD);
    end

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed bench for button_press_classifier with LONG_CYCLES=8, GAP_CYCLES=4.
// Cycle i drives debounced before edge i and checks outputs #1 after edge i.
// Output vector is {short_press, long_press, double_press, held}.
module tb_button_press_classifier;

    logic clk = 1'b0;
    logic rst;
    logic debounced;
    logic short_press;
    logic long_press;
    logic double_press;
    logic held;

    int checks = 0;
    int errors = 0;

    wire [3:0] obs = {short_press, long_press, double_press, held};

    button_press_classifier #(
        .LONG_CYCLES (8),
        .GAP_CYCLES  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .debounced    (debounced),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_press (double_press),
        .held         (held)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        rst       = 1'b1;
        debounced = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = 4'b0000;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset cycle %0d: got %b expected %b", i, obs, exp);
            end
        end
        rst       = 1'b0;
        debounced = 1'b0;
        tick();
        exp = 4'b0000;
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", obs, exp);
        end
    endtask

    // Pressed edges 0..2, release at edge 3, short at edge 3+4.
    task automatic test_short();
        logic [3:0] exp;
        for (int i = 0; i < 10; i++) begin
            debounced = (i < 3);
            tick();
            exp = (i == 7) ? 4'b1000 : 4'b0000;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL short cycle %0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    // Pressed edges 0..19: long at edge 8, held until release edge 20.
    task automatic test_long();
        logic [3:0] exp;
        for (int i = 0; i < 25; i++) begin
            debounced = (i < 20);
            tick();
            if (i == 8)
                exp = 4'b0101;
            else if (i > 8 && i < 20)
                exp = 4'b0001;
            else
                exp = 4'b0000;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL long cycle %0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    // 1,1,0,0,1,1,0...: double on the second release edge 6.
    task automatic test_double();
        logic [3:0] exp;
        for (int i = 0; i < 12; i++) begin
            debounced = (i < 2) || (i == 4) || (i == 5);
            tick();
            exp = (i == 6) ? 4'b0010 : 4'b0000;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL double cycle %0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    // Release sampled at edge 8 with cnt=7: no long, short at edge 12.
    task automatic test_release_at_long_term();
        logic [3:0] exp;
        for (int i = 0; i < 15; i++) begin
            debounced = (i < 8);
            tick();
            exp = (i == 12) ? 4'b1000 : 4'b0000;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL release_at_term cycle %0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    // Release at edge 2, second press sampled at edge 6 with gap cnt=3.
    task automatic test_press_at_gap_term();
        logic [3:0] exp;
        for (int i = 0; i < 12; i++) begin
            debounced = (i < 2) || (i == 6) || (i == 7);
            tick();
            exp = (i == 8) ? 4'b0010 : 4'b0000;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL press_at_gap_term cycle %0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    // Reset sampled at edge 6 (cnt=5) with button held: restart at edge 7,
    // long at edge 15, held through edge 18, released at edge 19.
    task automatic test_reset_mid_gesture();
        logic [3:0] exp;
        for (int i = 0; i < 22; i++) begin
            debounced = (i < 19);
            rst       = (i == 6);
            tick();
            if (i == 15)
                exp = 4'b0101;
            else if (i > 15 && i < 19)
                exp = 4'b0001;
            else
                exp = 4'b0000;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_mid_gesture cycle %0d: got %b expected %b", i, obs, exp);
            end
        end
        rst = 1'b0;
    endtask

    // Short press immediately followed by a fresh short press.
    task automatic test_back_to_back();
        logic [3:0] exp;
        for (int i = 0; i < 16; i++) begin
            debounced = (i < 1) || (i == 6);
            tick();
            exp = (i == 5 || i == 11) ? 4'b1000 : 4'b0000;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        debounced = 1'b0;
        test_reset();
        test_short();
        test_long();
        test_double();
        test_release_at_long_term();
        test_press_at_gap_term();
        test_reset_mid_gesture();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
